// File: rtl/wb_sched.sv
// rtl/wb_sched.sv - register-file write-back scheduler (ALU > held FPU > new FPU); optional scoreboard via WB_SCOREBOARD_EN
module wb_sched #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  alu_addr,
   input  logic [31:0] alu_dd_val,
   input  logic [5:0]  fpu_addr,
   input  logic [31:0] fpu_dd_val,
   input  logic        issue_valid,
   input  logic [5:0]  issue_dd,
   input  logic        issue_fpu,
   output logic        wr_en,
   output logic [5:0]  wr_addr,
   output logic [31:0] wr_val,
   output logic        stall,
   output logic [63:0] busy,
   output logic        ovf
);
   localparam int PW = (DEPTH > 2) ? 2 : 1;
   localparam int CW = (DEPTH > 3) ? 3 : 2;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW-1:0] HIGH = CW'(DEPTH - 1);

   logic [5:0]    q_addr [DEPTH];
   logic [31:0]   q_val  [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;

   logic        alu_hit, fpu_hit, have, pop, direct, push_req, push, drop;
   logic        win_en, win_fpu, waw;
   logic [5:0]  win_addr;
   logic [31:0] win_val;

   // Arbitration: ALU first, then the oldest held FPU result, then a fresh FPU result
   always_comb begin
      alu_hit  = (alu_addr != 6'd0);
      fpu_hit  = (fpu_addr != 6'd0);
      have     = (count != '0);
      pop      = !alu_hit && have;
      direct   = !alu_hit && !have && fpu_hit;
      push_req = fpu_hit && !direct;
      push     = push_req && ((count != FULL) || pop);
      drop     = push_req && !push;
      win_en   = alu_hit || have || fpu_hit;
      win_fpu  = !alu_hit && (have || fpu_hit);
      win_addr = 6'd0;
      win_val  = 32'd0;
      if (alu_hit) begin
         win_addr = alu_addr;
         win_val  = alu_dd_val;
      end else if (have) begin
         win_addr = q_addr[rd_ptr];
         win_val  = q_val[rd_ptr];
      end else if (fpu_hit) begin
         win_addr = fpu_addr;
         win_val  = fpu_dd_val;
      end
   end

   // Hold issue one entry early so a result already in flight still has room
   assign stall = !rst && ((count >= HIGH) || waw);

   // Holding FIFO, registered write port and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         wr_en   <= 1'b0;
         wr_addr <= 6'd0;
         wr_val  <= 32'd0;
         ovf     <= 1'b0;
      end else begin
         if (push) begin
            q_addr[wr_ptr] <= fpu_addr;
            q_val[wr_ptr]  <= fpu_dd_val;
            wr_ptr         <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
         wr_en <= win_en;
         if (win_en) begin
            wr_addr <= win_addr;
            wr_val  <= win_val;
         end
         if (drop)
            ovf <= 1'b1;
      end
   end

`ifdef WB_SCOREBOARD_EN
   logic [63:0] busy_q, set_mask, clr_mask;

   assign waw      = issue_valid && busy_q[issue_dd];
   assign set_mask = (issue_valid && !stall && issue_fpu && (issue_dd != 6'd0))
                     ? (64'd1 << issue_dd) : 64'd0;
   assign clr_mask = (win_en && win_fpu) ? (64'd1 << win_addr) : 64'd0;
   assign busy     = busy_q;

   // Pending FPU destinations; a new issue wins over a same-edge retirement
   always_ff @(posedge clk) begin
      if (rst)
         busy_q <= 64'd0;
      else
         busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~64'd1;
   end
`else
   logic unused_issue;

   assign waw          = 1'b0;
   assign busy         = 64'd0;
   assign unused_issue = ^{issue_valid, issue_dd, issue_fpu};
`endif
endmodule

// File: tb/tb_wb_sched.sv
// tb/tb_wb_sched.sv - randomized and directed self-checking bench for wb_sched
module tb_wb_sched;
   localparam int DEPTH = 2;
`ifdef WB_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  alu_addr, fpu_addr, issue_dd;
   logic [31:0] alu_dd_val, fpu_dd_val;
   logic        issue_valid, issue_fpu;
   logic        wr_en, stall, ovf;
   logic [5:0]  wr_addr;
   logic [31:0] wr_val;
   logic [63:0] busy;

   int checks = 0;
   int errors = 0;

   // reference state
   logic [37:0] mq[$];
   logic        m_en, m_ovf;
   logic [5:0]  m_addr;
   logic [31:0] m_val;
   logic [63:0] m_busy;

   wb_sched #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_addr(alu_addr), .alu_dd_val(alu_dd_val),
      .fpu_addr(fpu_addr), .fpu_dd_val(fpu_dd_val),
      .issue_valid(issue_valid), .issue_dd(issue_dd), .issue_fpu(issue_fpu),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_val(wr_val),
      .stall(stall), .busy(busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One cycle: drive, check stall, advance the model, check registered outputs
   task automatic step(input logic r, input logic [5:0] aa, input logic [31:0] av,
                       input logic [5:0] fa, input logic [31:0] fv,
                       input logic iv, input logic [5:0] idd, input logic ifp);
      logic        exp_stall, acc, from_fpu, took;
      logic [37:0] e;
      @(negedge clk);
      rst = r; alu_addr = aa; alu_dd_val = av; fpu_addr = fa; fpu_dd_val = fv;
      issue_valid = iv; issue_dd = idd; issue_fpu = ifp;
      #1;
      exp_stall = !r && ((mq.size() >= DEPTH - 1) || (SB && iv && m_busy[idd]));
      chk("stall", {63'd0, stall}, {63'd0, exp_stall});
      if (r) begin
         mq.delete();
         m_en = 0; m_addr = 0; m_val = 0; m_busy = 0; m_ovf = 0;
      end else begin
         acc = iv && !exp_stall && ifp && (idd != 0);
         from_fpu = 0; took = 0; m_en = 1;
         if (aa != 0) begin
            m_addr = aa; m_val = av;
         end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_addr = e[37:32]; m_val = e[31:0]; from_fpu = 1;
         end else if (fa != 0) begin
            m_addr = fa; m_val = fv; from_fpu = 1; took = 1;
         end else
            m_en = 0;
         if (fa != 0 && !took) begin
            if (mq.size() < DEPTH) mq.push_back({fa, fv});
            else m_ovf = 1;
         end
         if (SB) begin
            if (from_fpu) m_busy[m_addr] = 1'b0;
            if (acc) m_busy[idd] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      chk("wr_en", {63'd0, wr_en}, {63'd0, m_en});
      if (m_en) chk("wr_addr", {58'd0, wr_addr}, {58'd0, m_addr});
      chk("wr_val", {32'd0, wr_val}, {32'd0, m_val});
      chk("busy", busy, m_busy);
      chk("ovf", {63'd0, ovf}, {63'd0, m_ovf});
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [5:0] ra, rf, rd;
      m_en = 0; m_addr = 0; m_val = 0; m_busy = 0; m_ovf = 0;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_en", {63'd0, wr_en}, 64'd0);
      chk("rst_val", {32'd0, wr_val}, 64'd0);

      // single ALU write
      step(0, 5, 32'h1234, 0, 0, 0, 0, 0);
      chk("alu_addr", {58'd0, wr_addr}, 64'd5);
      chk("alu_val", {32'd0, wr_val}, 64'h1234);
      idle();
      chk("hold_val", {32'd0, wr_val}, 64'h1234);

      // ALU/FPU collision
      step(0, 3, 32'hA, 40, 32'hB, 0, 0, 0);
      chk("col1_addr", {58'd0, wr_addr}, 64'd3);
      idle();
      chk("col2_addr", {58'd0, wr_addr}, 64'd40);
      chk("col2_val", {32'd0, wr_val}, 64'hB);
      chk("col_stall", {63'd0, stall}, 64'd0);

      // fill, overflow and drain
      step(0, 1, 32'h11, 33, 32'h33, 0, 0, 0);
      step(0, 2, 32'h22, 34, 32'h34, 0, 0, 0);
      step(0, 4, 32'h44, 35, 32'h35, 0, 0, 0);
      chk("ovf_set", {63'd0, ovf}, 64'd1);
      idle();
      chk("drain1", {58'd0, wr_addr}, 64'd33);
      idle();
      chk("drain2", {58'd0, wr_addr}, 64'd34);
      idle();
      chk("drain_end", {63'd0, wr_en}, 64'd0);

      // reset with two entries held
      step(0, 1, 0, 33, 1, 0, 0, 0);
      step(0, 2, 0, 34, 2, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle();
      chk("rst_mid_en", {63'd0, wr_en}, 64'd0);
      chk("rst_mid_ovf", {63'd0, ovf}, 64'd0);
      chk("rst_mid_stall", {63'd0, stall}, 64'd0);

`ifdef WB_SCOREBOARD_EN
      step(0, 0, 0, 0, 0, 1, 36, 1);
      chk("sb_set", {63'd0, busy[36]}, 64'd1);
      step(0, 0, 0, 0, 0, 1, 36, 1);
      step(0, 0, 0, 36, 32'h36, 0, 0, 0);
      chk("sb_clr", {63'd0, busy[36]}, 64'd0);
      step(0, 0, 0, 37, 32'h37, 1, 37, 1);
      chk("sb_setclr", {63'd0, busy[37]}, 64'd1);
      step(0, 0, 0, 37, 32'h37, 0, 0, 0);
`endif

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         ra = ($urandom_range(1) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         rf = ($urandom_range(2) == 0) ? 6'($urandom_range(32, 39)) : 6'd0;
         rd = ($urandom_range(7) == 0) ? 6'd0 : 6'($urandom_range(32, 39));
         step($urandom_range(79) == 0, ra, $urandom, rf, $urandom,
              1'($urandom_range(1)), rd, 1'($urandom_range(1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_sched.md
WB_SCHED -- requirements
Module: wb_sched

Interface
REQ-001 The module SHALL have parameter DEPTH, default 2, giving the number of FPU-result holding entries (2..4).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port alu_addr, input, 6, ALU result destination; 0 = no write.
REQ-005 The module SHALL have port alu_dd_val, input, 32, ALU result value.
REQ-006 The module SHALL have port fpu_addr, input, 6, FPU result destination; 0 = no write.
REQ-007 The module SHALL have port fpu_dd_val, input, 32, FPU result value.
REQ-008 The module SHALL have port issue_valid, input, 1, an instruction is issued this cycle.
REQ-009 The module SHALL have port issue_dd, input, 6, destination of the issued instruction.
REQ-010 The module SHALL have port issue_fpu, input, 1, the issued instruction is multi-cycle FPU.
REQ-011 The module SHALL have port wr_en, output, 1, register-file write strobe (registered).
REQ-012 The module SHALL have port wr_addr, output, 6, register-file write address (registered).
REQ-013 The module SHALL have port wr_val, output, 32, register-file write data (registered).
REQ-014 The module SHALL have port stall, output, 1, combinational; issue must be held this cycle.
REQ-015 The module SHALL have port busy, output, 64, per-register pending-FPU-write scoreboard; bit 0 always 0.
REQ-016 The module SHALL have port ovf, output, 1, sticky error: an FPU result was dropped.

Function
REQ-017 Write port arbitration SHALL use fixed priority: ALU result > oldest holding entry > new FPU result.
REQ-018 The winner presented in cycle N SHALL appear on wr_en/wr_addr/wr_val in cycle N+1; wr_en=0 when no candidate.
REQ-019 wr_val SHALL hold its previous value when wr_en=0.
REQ-020 A new FPU result that does not win SHALL be appended to the holding FIFO in arrival order.
REQ-021 The FIFO SHALL be circular, with read and write pointers wrapping modulo DEPTH and count 0..DEPTH.
REQ-022 Simultaneous pop and push SHALL leave count unchanged and preserve order.
REQ-023 When count==0 and there is no ALU write, a new FPU result SHALL go straight to the write port and not enter the FIFO.
REQ-024 An FPU result arriving while count==DEPTH and not popped this cycle SHALL be dropped and SHALL set ovf, which stays set until reset.
REQ-025 stall SHALL be 1 when count >= DEPTH-1.
REQ-026 stall SHALL be 1 when issue_valid=1 and busy[issue_dd]=1 (WAW hazard).
REQ-027 Otherwise stall SHALL be 0.
REQ-028 An accepted issue (issue_valid=1, stall=0, issue_fpu=1, issue_dd!=0) SHALL set busy[issue_dd] at the next edge.
REQ-029 busy[a] SHALL clear at the edge where a committed write with wr_addr=a is registered from an FPU source (FIFO or direct).
REQ-030 A set and a clear of the same busy bit in the same cycle SHALL result in the bit being set.
REQ-031 ALU writes SHALL never clear busy bits.

Reset
REQ-032 With rst=1 at a clock edge: wr_en=0, wr_addr=0, wr_val=0, busy=0, ovf=0, FIFO count and pointers=0.
REQ-033 Reset mid-operation SHALL discard FIFO contents without issuing writes.
REQ-034 stall SHALL be 0 during reset.

Configuration
REQ-035 With macro WB_SCOREBOARD_EN defined, busy tracking and the WAW stall (REQ-026, REQ-028..031) SHALL be implemented.
REQ-036 Without WB_SCOREBOARD_EN, busy SHALL be constant 0, REQ-026 SHALL not apply, and no scoreboard storage SHALL be built.

Verification
REQ-037 Reset release, then alu_addr=5, alu_dd_val=0x1234 for one cycle -> next cycle wr_en=1, wr_addr=5, wr_val=0x1234, busy=0.
REQ-038 Collision: alu_addr=3/0xA and fpu_addr=40/0xB in the same cycle -> cycle+1 write 3/0xA; cycle+2 write 40/0xB; count returns to 0.
REQ-039 DEPTH=2; ALU writes every cycle while FPU results 33,34 arrive on consecutive cycles -> stall=1 from count=1 onward; a third FPU result (35) while full -> ovf=1 and 35 is never written.
REQ-040 Scoreboard (WB_SCOREBOARD_EN defined): issue FPU dd=36 -> busy[36]=1; a reissue to 36 stalls; fpu_addr=36 commits -> busy[36]=0 the same edge wr_en=1; stall releases.
REQ-041 Same-cycle set/clear: an FPU result for 37 commits on the same edge as a new FPU issue to 37 -> busy[37] remains 1.
REQ-042 rst=1 pulsed with 2 FIFO entries held -> no further writes, count=0, ovf=0, busy=0.
